unidade_controle: RTL and testbench

Multicycle control unit for the RV64 core. Sequences the shared datapath (PC, IR, register file, immediate extender, ALU, data memory) through fetch, decode, execute, memory and writeback. Drives the immediate-type select consumed by the immediate extender and runs a request/acknowledge handshake with the instruction and data memories. Counts retired instructions and stops on EBREAK or an illegal opcode.

---
 rtl/unidade_controle.sv | 182 ++++++++++++++++++
 tb/tb_unidade_controle.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// ============================================================================
// unidade_controle -- multicycle FSM sequencing the RV64 shared datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module unidade_controle #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [2:0]           imm_sel,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    K_R, K_IALU, K_LOAD, K_STORE, K_BRANCH, K_LUI, K_JAL, K_JALR,
    K_SYS, K_EBREAK, K_ILLEGAL
  } kind_t;

  localparam logic [2:0] c_imm_i  = 3'd0;
  localparam logic [2:0] c_imm_s  = 3'd1;
  localparam logic [2:0] c_imm_sb = 3'd2;
  localparam logic [2:0] c_imm_u  = 3'd3;
  localparam logic [2:0] c_imm_uj = 3'd4;

  state_t                 r_state, w_next;
  kind_t                  r_kind, w_kind;
  logic [2:0]             r_imm_sel, w_imm_sel;
  logic                   w_taken;
  logic [INSTRET_W-1:0]   r_instret;

  // Opcode classification; only meaningful while IR is stable (DECODE).
  always_comb begin
    w_kind    = K_ILLEGAL;
    w_imm_sel = c_imm_i;
    case (instr[6:0])
      7'b0110011: w_kind = K_R;
      7'b0010011: w_kind = K_IALU;
      7'b0000011: w_kind = K_LOAD;
      7'b1100111: w_kind = K_JALR;
      7'b1110011: w_kind = (instr[31:7] == 25'h0002000) ? K_EBREAK : K_SYS;
      7'b0100011: begin w_kind = K_STORE;  w_imm_sel = c_imm_s;  end
      7'b1100011: begin w_kind = K_BRANCH; w_imm_sel = c_imm_sb; end
      7'b0110111: begin w_kind = K_LUI;    w_imm_sel = c_imm_u;  end
      7'b1101111: begin w_kind = K_JAL;    w_imm_sel = c_imm_uj; end
      default:    w_kind = K_ILLEGAL;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (instr[14:12])
      3'b000:  w_taken = alu_zero;
      3'b001:  w_taken = !alu_zero;
      3'b100:  w_taken = alu_lt;
      3'b101:  w_taken = !alu_lt;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    imm_sel   = 3'd0;
    alu_src_b = 1'b0;
    alu_op    = 2'd0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    case (r_state)
      S_FETCH: begin
        // Gated by rst_n so the request drops the moment reset asserts.
        imem_req = rst_n;
        ir_write = rst_n & imem_ack;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        imm_sel = w_imm_sel;
        case (w_kind)
          K_EBREAK:  w_next = S_HALT;
          K_ILLEGAL: w_next = S_TRAP;
          default:   w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        imm_sel = r_imm_sel;
        case (r_kind)
          K_R:    begin alu_op = 2'd2; w_next = S_WB; end
          K_IALU: begin alu_src_b = 1'b1; alu_op = 2'd2; w_next = S_WB; end
          K_LOAD, K_STORE: begin alu_src_b = 1'b1; w_next = S_MEM; end
          K_JALR: begin alu_src_b = 1'b1; w_next = S_WB; end
          K_BRANCH: begin
            alu_op   = 2'd1;
            pc_write = 1'b1;
            pc_src   = w_taken ? 2'd1 : 2'd0;
            w_next   = S_FETCH;
          end
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        imm_sel  = r_imm_sel;
        dmem_req = 1'b1;
        dmem_we  = (r_kind == K_STORE);
        if (dmem_ack) begin
          if (r_kind == K_STORE) begin
            pc_write = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        imm_sel   = r_imm_sel;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        w_next    = S_FETCH;
        case (r_kind)
          K_LOAD: wb_sel = 2'd1;
          K_LUI:  wb_sel = 2'd3;
          K_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
          K_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
          default: wb_sel = 2'd0;
        endcase
      end
      S_HALT:  w_next = S_HALT;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_kind    <= K_R;
      r_imm_sel <= 3'd0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_kind    <= w_kind;
        r_imm_sel <= w_imm_sel;
      end
      // Every retiring path ends with exactly one pc_write.
      if (pc_write) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  assign halted  = (r_state == S_HALT);
  assign trap    = (r_state == S_TRAP);
  assign instret = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle.sv
// ============================================================================
// tb_unidade_controle -- directed vector bench for the multicycle control unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unidade_controle;

  localparam int IW = 4;

  typedef struct packed {
    logic          imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0]    pc_src;
    logic [2:0]    imm_sel;
    logic          alu_src_b;
    logic [1:0]    alu_op;
    logic          reg_write;
    logic [1:0]    wb_sel;
    logic          halted, trap;
    logic [IW-1:0] instret;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        az, alt, ia, da;
    out_t        exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   instr = 32'h0;
  logic          alu_zero = 1'b0, alu_lt = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic          imem_req, dmem_req, dmem_we, ir_write, pc_write;
  logic [1:0]    pc_src, alu_op, wb_sel;
  logic [2:0]    imm_sel;
  logic          alu_src_b, reg_write, halted, trap;
  logic [IW-1:0] instret;
  out_t          act;

  int checks = 0;
  int errors = 0;
  int row = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  unidade_controle #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .imm_sel(imm_sel), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .halted(halted), .trap(trap), .instret(instret)
  );

  assign act = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, imm_sel,
                alu_src_b, alu_op, reg_write, wb_sel, halted, trap, instret};

  function automatic out_t o(input logic imr, dmr, we, irw, pcw, input logic [1:0] pcs,
                             input logic [2:0] ims, input logic asb, input logic [1:0] aop,
                             input logic rw, input logic [1:0] wbs, input int ret);
    out_t r;
    r.imem_req = imr; r.dmem_req = dmr; r.dmem_we = we; r.ir_write = irw;
    r.pc_write = pcw; r.pc_src = pcs; r.imm_sel = ims; r.alu_src_b = asb;
    r.alu_op = aop; r.reg_write = rw; r.wb_sel = wbs; r.halted = 1'b0; r.trap = 1'b0;
    r.instret = ret[IW-1:0];
    return r;
  endfunction

  function automatic out_t fa(input int ret);  // FETCH with ack
    return o(1,0,0,1,0,0,0,0,0,0,0,ret);
  endfunction

  function automatic out_t idle(input logic [2:0] ims, input int ret);
    return o(0,0,0,0,0,0,ims,0,0,0,0,ret);
  endfunction

  task automatic add(input logic [31:0] i, input logic az, alt, ia, da, input out_t e);
    vec_t v;
    v.instr = i; v.az = az; v.alt = alt; v.ia = ia; v.da = da; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic compare(input string name, input out_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s (row %0d): got %h required %h", name, row, act, e);
    end
  endtask

  // Drive at the negedge, check 1 ns later, then wait for the next negedge.
  task automatic apply(input vec_t v, input string name);
    instr = v.instr; alu_zero = v.az; alu_lt = v.alt; imem_ack = v.ia; dmem_ack = v.da;
    #1;
    compare(name, v.exp);
    if (imem_req && dmem_req) begin
      errors++;
      $display("FAIL req_overlap (row %0d): got both 1 required not both", row);
    end
    row++;
    @(negedge clk);
  endtask

  task automatic run_addi(input int ret);
    vec_t v;
    v.instr = 32'h00500093; v.az = 0; v.alt = 0; v.da = 0;
    v.ia = 1; v.exp = fa(ret);                        apply(v, "addi_fetch");
    v.ia = 0; v.exp = idle(0, ret);                   apply(v, "addi_decode");
    v.exp = o(0,0,0,0,0,0,0,1,2,0,0,ret);             apply(v, "addi_exec");
    v.exp = o(0,0,0,0,1,0,0,0,0,1,0,ret);             apply(v, "addi_wb");
  endtask

  task automatic mid_reset(input string name);
    #2 rst_n = 1'b0;
    #1 compare(name, idle(0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    // ADDI x1,x0,5 -- stray acks outside their request are ignored
    add(32'h00500093,0,0,1,0, fa(0));
    add(32'h00500093,0,0,1,0, idle(0,0));
    add(32'h00500093,0,0,0,1, o(0,0,0,0,0,0,0,1,2,0,0,0));
    add(32'h00500093,0,0,0,0, o(0,0,0,0,1,0,0,0,0,1,0,0));
    // branches: BEQ taken/not, BNE taken, BLT taken, BGE not, funct3 010 not
    add(32'h00000463,1,0,1,0, fa(1));
    add(32'h00000463,1,0,0,0, idle(2,1));
    add(32'h00000463,1,0,0,0, o(0,0,0,0,1,1,2,0,1,0,0,1));
    add(32'h00000463,0,0,1,0, fa(2));
    add(32'h00000463,0,0,0,0, idle(2,2));
    add(32'h00000463,0,0,0,0, o(0,0,0,0,1,0,2,0,1,0,0,2));
    add(32'h00001463,0,0,1,0, fa(3));
    add(32'h00001463,0,0,0,0, idle(2,3));
    add(32'h00001463,0,0,0,0, o(0,0,0,0,1,1,2,0,1,0,0,3));
    add(32'h00004463,0,1,1,0, fa(4));
    add(32'h00004463,0,1,0,0, idle(2,4));
    add(32'h00004463,0,1,0,0, o(0,0,0,0,1,1,2,0,1,0,0,4));
    add(32'h00005463,0,1,1,0, fa(5));
    add(32'h00005463,0,1,0,0, idle(2,5));
    add(32'h00005463,0,1,0,0, o(0,0,0,0,1,0,2,0,1,0,0,5));
    add(32'h00002463,1,0,1,0, fa(6));
    add(32'h00002463,1,0,0,0, idle(2,6));
    add(32'h00002463,1,0,0,0, o(0,0,0,0,1,0,2,0,1,0,0,6));
    // LD with dmem_ack three cycles late
    add(32'h0000B103,0,0,1,0, fa(7));
    add(32'h0000B103,0,0,0,0, idle(0,7));
    add(32'h0000B103,0,0,0,0, o(0,0,0,0,0,0,0,1,0,0,0,7));
    add(32'h0000B103,0,0,1,0, o(0,1,0,0,0,0,0,0,0,0,0,7));
    add(32'h0000B103,0,0,0,0, o(0,1,0,0,0,0,0,0,0,0,0,7));
    add(32'h0000B103,0,0,0,0, o(0,1,0,0,0,0,0,0,0,0,0,7));
    add(32'h0000B103,0,0,0,1, o(0,1,0,0,0,0,0,0,0,0,0,7));
    add(32'h0000B103,0,0,0,0, o(0,0,0,0,1,0,0,0,0,1,1,7));
    // SD with one imem wait cycle
    add(32'h0020B023,0,0,0,1, o(1,0,0,0,0,0,0,0,0,0,0,8));
    add(32'h0020B023,0,0,1,0, fa(8));
    add(32'h0020B023,0,0,0,0, idle(1,8));
    add(32'h0020B023,0,0,0,0, o(0,0,0,0,0,0,1,1,0,0,0,8));
    add(32'h0020B023,0,0,0,1, o(0,1,1,0,1,0,1,0,0,0,0,8));
    // JAL, JALR, LUI, ADD
    add(32'h0080006F,0,0,1,0, fa(9));
    add(32'h0080006F,0,0,0,0, idle(4,9));
    add(32'h0080006F,0,0,0,0, idle(4,9));
    add(32'h0080006F,0,0,0,0, o(0,0,0,0,1,1,4,0,0,1,2,9));
    add(32'h000080E7,0,0,1,0, fa(10));
    add(32'h000080E7,0,0,0,0, idle(0,10));
    add(32'h000080E7,0,0,0,0, o(0,0,0,0,0,0,0,1,0,0,0,10));
    add(32'h000080E7,0,0,0,0, o(0,0,0,0,1,2,0,0,0,1,2,10));
    add(32'h123450B7,0,0,1,0, fa(11));
    add(32'h123450B7,0,0,0,0, idle(3,11));
    add(32'h123450B7,0,0,0,0, idle(3,11));
    add(32'h123450B7,0,0,0,0, o(0,0,0,0,1,0,3,0,0,1,3,11));
    add(32'h002081B3,0,0,1,0, fa(12));
    add(32'h002081B3,0,0,0,0, idle(0,12));
    add(32'h002081B3,0,0,0,0, o(0,0,0,0,0,0,0,0,2,0,0,12));
    add(32'h002081B3,0,0,0,0, o(0,0,0,0,1,0,0,0,0,1,0,12));

    // Reset values, with an ack present to prove it is ignored
    #1 rst_n = 1'b0;
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1 compare("reset_values", idle(0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], "table");

    // instret wraps: 13 + 3 = 16 -> 0
    run_addi(13);
    run_addi(14);
    run_addi(15);

    // EBREAK halts without retiring; further acks start nothing
    v.instr = 32'h00100073; v.az = 0; v.alt = 0; v.da = 0;
    v.ia = 1; v.exp = fa(0);        apply(v, "ebreak_fetch");
    v.ia = 0; v.exp = idle(0, 0);   apply(v, "ebreak_decode");
    v.exp = idle(0, 0); v.exp.halted = 1'b1; v.ia = 1;
    for (int k = 0; k < 3; k++) apply(v, "halted");

    mid_reset("reset_from_halt");

    // Illegal opcode traps; reset clears it and FETCH restarts
    v.instr = 32'h0000007F; v.ia = 1; v.exp = fa(0); apply(v, "trap_fetch");
    v.ia = 0; v.exp = idle(0, 0);                   apply(v, "trap_decode");
    v.exp = idle(0, 0); v.exp.trap = 1'b1; v.ia = 1;
    for (int k = 0; k < 3; k++) apply(v, "trapped");
    mid_reset("reset_from_trap");
    v.ia = 0; v.exp = o(1,0,0,0,0,0,0,0,0,0,0,0);    apply(v, "fetch_wait");
    instr = 32'h0; imem_ack = 1'b0;
    mid_reset("reset_mid_fetch");
    v.exp = o(1,0,0,0,0,0,0,0,0,0,0,0);              apply(v, "fetch_restart");

    // Reset during a load's MEM wait drops dmem_req and discards the retire count
    run_addi(0);
    v.instr = 32'h0000B103;
    v.ia = 1; v.exp = fa(1);                         apply(v, "ld_fetch");
    v.ia = 0; v.exp = idle(0, 1);                    apply(v, "ld_decode");
    v.exp = o(0,0,0,0,0,0,0,1,0,0,0,1);              apply(v, "ld_exec");
    v.exp = o(0,1,0,0,0,0,0,0,0,0,0,1);              apply(v, "ld_mem_wait");
    instr = 32'h0000B103; dmem_ack = 1'b0;
    mid_reset("reset_mid_mem");
    v.exp = o(1,0,0,0,0,0,0,0,0,0,0,0);              apply(v, "fetch_after_mem_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
